// File: rtl/text_writer.sv
// Character terminal writer: turns a stream of character codes into display
// memory writes, tracks the cursor and runs row / full-screen clear sequences.
// Handshake: a character is taken on a rising edge where char_valid and
// char_ready are both high; char_ready is high only while no clear runs.
module text_writer #(
    parameter int          COLS = 40,
    parameter int          ROWS = 30,
    parameter logic [7:0]  FILL = 8'h20
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        dis_mem_we,
    output logic [11:0] dis_mem_addr,
    output logic [7:0]  dis_mem_data,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

    localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    localparam logic [11:0] COLS_W    = 12'(COLS);
    localparam logic [11:0] LAST_CELL = 12'(ROWS * COLS - 1);

    state_t      state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    // Current and final address of the running clear sequence.
    logic [11:0] clr_addr_q, clr_addr_d;
    logic [11:0] clr_last_q, clr_last_d;

    logic [4:0]  next_row;
    logic [11:0] cell_addr;
    logic [11:0] next_base;

    // Next-state, cursor and write-port computation for all registers.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        clr_addr_d = clr_addr_q;
        clr_last_d = clr_last_q;

        next_row  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
        cell_addr = 12'(row_q) * COLS_W + 12'(col_q);
        next_base = 12'(next_row) * COLS_W;

        case (state_q)
            IDLE: begin
                if (char_valid) begin
                    if (char_in >= 8'h20 && char_in <= 8'h7E) begin
                        we_d   = 1'b1;
                        addr_d = cell_addr;
                        data_d = char_in;
                        if (col_q == LAST_COL) begin
                            // Line wrap: the new row is blanked before use.
                            col_d      = 6'd0;
                            row_d      = next_row;
                            state_d    = CLR_ROW;
                            clr_addr_d = next_base;
                            clr_last_d = next_base + COLS_W - 12'd1;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end else begin
                        case (char_in)
                            8'h0A: begin
                                col_d      = 6'd0;
                                row_d      = next_row;
                                state_d    = CLR_ROW;
                                clr_addr_d = next_base;
                                clr_last_d = next_base + COLS_W - 12'd1;
                            end
                            8'h0D: col_d = 6'd0;
                            8'h08: begin
                                if (col_q != 6'd0) begin
                                    col_d  = col_q - 6'd1;
                                    we_d   = 1'b1;
                                    addr_d = cell_addr - 12'd1;
                                    data_d = FILL;
                                end
                            end
                            8'h0C: begin
                                col_d      = 6'd0;
                                row_d      = 5'd0;
                                state_d    = CLR_ALL;
                                clr_addr_d = 12'd0;
                                clr_last_d = LAST_CELL;
                            end
                            default: ;  // unsupported codes are swallowed
                        endcase
                    end
                end
            end
            CLR_ROW, CLR_ALL: begin
                we_d   = 1'b1;
                addr_d = clr_addr_q;
                data_d = FILL;
                if (clr_addr_q == clr_last_q) begin
                    state_d = IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, cursor and write-port registers; clr aborts any clear in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            col_q      <= 6'd0;
            row_q      <= 5'd0;
            we_q       <= 1'b0;
            addr_q     <= 12'd0;
            data_q     <= 8'd0;
            clr_addr_q <= 12'd0;
            clr_last_q <= 12'd0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            clr_addr_q <= clr_addr_d;
            clr_last_q <= clr_last_d;
        end
    end

    assign char_ready   = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign dis_mem_we   = we_q;
    assign dis_mem_addr = addr_q;
    assign dis_mem_data = data_q;
    assign cursor_col   = col_q;
    assign cursor_row   = row_q;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer at default parameters (40x30, fill 0x20).
module tb_text_writer;

    logic        clk;
    logic        clr;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        dis_mem_we;
    logic [11:0] dis_mem_addr;
    logic [7:0]  dis_mem_data;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    // Observed writes {addr, data}, and the writes the bench expects.
    logic [19:0] wr_q[$];
    logic [19:0] exp_q[$];

    text_writer dut (
        .clk          (clk),
        .clr          (clr),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .dis_mem_we   (dis_mem_we),
        .dis_mem_addr (dis_mem_addr),
        .dis_mem_data (dis_mem_data),
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row),
        .busy         (busy)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor, sampled just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (dis_mem_we) wr_q.push_back({dis_mem_addr, dis_mem_data});
    end

    // Global watchdog.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All driver tasks start and end on a falling edge.
    task automatic do_reset();
        clr        = 1'b1;
        char_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic put(input logic [7:0] c);
        int n;
        n = 0;
        while (!char_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 5000) check("put_timeout", 1, 0);
        char_valid = 1'b1;
        char_in    = c;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 5000) check("idle_timeout", 1, 0);
    endtask

    task automatic goto_pos(input int r, input int c);
        do_reset();
        repeat (r) put(8'h0A);
        repeat (c) put(8'h2E);
        wait_idle();
    endtask

    task automatic expect_fill(input int base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({12'(base + i), 8'h20});
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) check({tag, "_write"}, wr_q[i], exp_q[i]);
    endtask

    task automatic clear_logs();
        wr_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int cnt;
        clr        = 1'b1;
        char_in    = 8'h00;
        char_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Reset state.
        check("rst_we", dis_mem_we, 0);
        check("rst_addr", dis_mem_addr, 0);
        check("rst_data", dis_mem_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", char_ready, 1);
        check("rst_col", cursor_col, 0);
        check("rst_row", cursor_row, 0);
        clr = 1'b0;

        // Two printables on consecutive cycles.
        put(8'h41);
        check("a_we", dis_mem_we, 1);
        check("a_addr", dis_mem_addr, 0);
        check("a_data", dis_mem_data, 8'h41);
        put(8'h42);
        check("b_we", dis_mem_we, 1);
        check("b_addr", dis_mem_addr, 1);
        check("b_data", dis_mem_data, 8'h42);
        check("b_col", cursor_col, 2);
        @(negedge clk);
        check("b_we_after", dis_mem_we, 0);

        // Printable at last column wraps and blanks row 1.
        goto_pos(0, 39);
        check("wrap_pre_col", cursor_col, 39);
        clear_logs();
        put(8'h5A);
        check("wrap_addr", dis_mem_addr, 39);
        check("wrap_data", dis_mem_data, 8'h5A);
        cnt = 0;
        while (!char_ready && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        check("wrap_ready_low", cnt, 40);
        exp_q.push_back({12'd39, 8'h5A});
        expect_fill(40, 40);
        compare_log("wrap");
        check("wrap_col", cursor_col, 0);
        check("wrap_row", cursor_row, 1);

        // LF on the last row wraps to row 0.
        goto_pos(29, 5);
        check("lf_pre_row", cursor_row, 29);
        clear_logs();
        put(8'h0A);
        check("lf_we", dis_mem_we, 0);
        wait_idle();
        expect_fill(0, 40);
        compare_log("lf");
        check("lf_col", cursor_col, 0);
        check("lf_row", cursor_row, 0);

        // Backspace mid-row, then at column 0.
        goto_pos(3, 10);
        clear_logs();
        put(8'h08);
        check("bs_we", dis_mem_we, 1);
        check("bs_addr", dis_mem_addr, 129);
        check("bs_data", dis_mem_data, 8'h20);
        check("bs_col", cursor_col, 9);
        check("bs_row", cursor_row, 3);
        put(8'h0D);
        put(8'h08);
        check("bs0_we", dis_mem_we, 0);
        check("bs0_col", cursor_col, 0);
        check("bs0_row", cursor_row, 3);

        // Form feed clears the whole screen.
        put(8'h41);
        clear_logs();
        put(8'h0C);
        cnt = 0;
        while (busy && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        check("ff_busy_cycles", cnt, 1200);
        exp_q.push_back({12'd3, 8'h41});
        exp_q.delete();
        expect_fill(0, 1200);
        compare_log("ff");
        check("ff_col", cursor_col, 0);
        check("ff_row", cursor_row, 0);

        // clr while a full clear runs aborts it.
        put(8'h41);
        clear_logs();
        put(8'h0C);
        cnt = 0;
        while (wr_q.size() < 500 && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        check("abort_reached", wr_q.size(), 500);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_we", dis_mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", char_ready, 1);
        @(negedge clk);
        check("abort_count", wr_q.size(), 500);

        // clr wins over a simultaneous character.
        put(8'h41);
        put(8'h42);
        clr        = 1'b1;
        char_valid = 1'b1;
        char_in    = 8'h51;
        @(negedge clk);
        clr        = 1'b0;
        char_valid = 1'b0;
        check("prio_we", dis_mem_we, 0);
        check("prio_col", cursor_col, 0);

        // Ignored codes and CR.
        goto_pos(4, 17);
        clear_logs();
        put(8'h07);
        check("bel_we", dis_mem_we, 0);
        put(8'hFF);
        check("ff8_we", dis_mem_we, 0);
        check("ign_col", cursor_col, 17);
        check("ign_row", cursor_row, 4);
        put(8'h0D);
        check("cr_we", dis_mem_we, 0);
        check("cr_col", cursor_col, 0);
        check("cr_row", cursor_row, 4);
        @(negedge clk);
        check("ign_writes", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
